ex_mem_branch_stage: RTL and testbench

EX/MEM pipeline register of the pipelined RV32 core, directly downstream of the ALU. It captures the ALU result and control for the MEM stage and resolves conditional branches from the ALU flags (cf/zf/vf/sf). It resolves jumps, computes the redirect target and issues a one-cycle redirect pulse. It also squashes the single wrong-path instruction that is in EX when the redirect fires.

---
 rtl/ex_mem_branch_stage_pkg.sv | 12 +
 rtl/ex_mem_branch_stage_if.sv | 33 +++
 rtl/ex_mem_branch_stage_branch_cond.sv | 20 ++
 rtl/ex_mem_branch_stage.sv | 85 ++++++++
 tb/tb_ex_mem_branch_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_branch_stage_pkg.sv
// ex_mem_branch_stage_pkg: shared core types for the EX/MEM branch stage
package ex_mem_branch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {CLS_NONE, CLS_BRANCH, CLS_JAL, CLS_JALR} instr_class_e;
  typedef enum logic {RUN, REDIR} state_e;
endpackage

// File: rtl/ex_mem_branch_stage_if.sv
// ex_mem_branch_stage_if: EX-side inputs, MEM-side outputs and redirect of the EX/MEM stage
interface ex_mem_branch_stage_if;
  import ex_mem_branch_stage_pkg::*;
  logic            stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_alu_r;
  logic            ex_cf, ex_zf, ex_vf, ex_sf;
  logic            ex_branch, ex_jal, ex_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rs2_data;
  logic [4:0]      ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write;
  logic            mem_valid;
  logic [XLEN-1:0] mem_result, mem_rs2_data;
  logic [4:0]      mem_rd;
  logic [2:0]      mem_funct3;
  logic            mem_reg_write, mem_mem_read, mem_mem_write;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign;
  modport master (
    output stall, ex_valid, ex_alu_r, ex_cf, ex_zf, ex_vf, ex_sf, ex_branch, ex_jal, ex_jalr,
           ex_funct3, ex_pc, ex_imm, ex_rs2_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
    input  mem_valid, mem_result, mem_rs2_data, mem_rd, mem_funct3, mem_reg_write, mem_mem_read,
           mem_mem_write, redirect, redirect_pc, misalign
  );
  modport slave (
    input  stall, ex_valid, ex_alu_r, ex_cf, ex_zf, ex_vf, ex_sf, ex_branch, ex_jal, ex_jalr,
           ex_funct3, ex_pc, ex_imm, ex_rs2_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
    output mem_valid, mem_result, mem_rs2_data, mem_rd, mem_funct3, mem_reg_write, mem_mem_read,
           mem_mem_write, redirect, redirect_pc, misalign
  );
endinterface

// File: rtl/ex_mem_branch_stage_branch_cond.sv
// branch_cond: branch condition from funct3 and subtract flags (cf=1 means no borrow)
module branch_cond
  import ex_mem_branch_stage_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_cf,
  input  logic       i_zf,
  input  logic       i_vf,
  input  logic       i_sf,
  output logic       o_cond
);
  always_comb begin
    o_cond = (i_funct3 == F3_BEQ)  ? i_zf :
             (i_funct3 == F3_BNE)  ? !i_zf :
             (i_funct3 == F3_BLT)  ? (i_sf != i_vf) :
             (i_funct3 == F3_BGE)  ? (i_sf == i_vf) :
             (i_funct3 == F3_BLTU) ? !i_cf :
             (i_funct3 == F3_BGEU) ? i_cf : 1'b0;
  end
endmodule

// File: rtl/ex_mem_branch_stage.sv
// ex_mem_branch_stage: EX/MEM pipeline register with branch/jump resolution and one-cycle redirect
module ex_mem_branch_stage
  import ex_mem_branch_stage_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  ex_mem_branch_stage_if.slave bus
);
  state_e          r_state;
  logic            r_squash, r_valid, r_reg_write, r_mem_read, r_mem_write;
  logic            r_redirect, r_misalign;
  logic [XLEN-1:0] r_result, r_rs2_data, r_redirect_pc;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  instr_class_e    w_cls;
  logic            w_cond, w_ok, w_link, w_taken, w_fire;
  logic [XLEN-1:0] w_target;

  branch_cond u_cond (
    .i_funct3 (bus.ex_funct3),
    .i_cf     (bus.ex_cf),
    .i_zf     (bus.ex_zf),
    .i_vf     (bus.ex_vf),
    .i_sf     (bus.ex_sf),
    .o_cond   (w_cond)
  );

  always_comb begin
    w_cls    = bus.ex_jalr ? CLS_JALR : bus.ex_jal ? CLS_JAL : bus.ex_branch ? CLS_BRANCH : CLS_NONE;
    w_ok     = bus.ex_valid & !r_squash;
    w_link   = (w_cls == CLS_JAL) | (w_cls == CLS_JALR);
    w_taken  = w_ok & (w_link | ((w_cls == CLS_BRANCH) & w_cond));
    w_fire   = !bus.stall & w_taken;
    w_target = (w_cls == CLS_JALR) ? {bus.ex_alu_r[XLEN-1:1], 1'b0} : bus.ex_pc + bus.ex_imm;
  end

  // REDIR always carries r_squash=1, so w_taken is 0 there and the state returns to RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_squash      <= 1'b0;
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_result      <= '0;
      r_rs2_data    <= '0;
      r_rd          <= '0;
      r_funct3      <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_misalign    <= 1'b0;
    end else begin
      if (!bus.stall) begin
        r_valid     <= w_ok;
        r_reg_write <= w_ok & bus.ex_reg_write;
        r_mem_read  <= w_ok & bus.ex_mem_read;
        r_mem_write <= w_ok & bus.ex_mem_write;
        r_result    <= w_link ? bus.ex_pc + 32'd4 : bus.ex_alu_r;
        r_rs2_data  <= bus.ex_rs2_data;
        r_rd        <= bus.ex_rd;
        r_funct3    <= bus.ex_funct3;
        r_squash    <= w_fire;
      end
      r_state    <= w_fire ? REDIR : RUN;
      r_redirect <= w_fire;
      if (w_fire) begin
        r_redirect_pc <= w_target;
        r_misalign    <= w_target[1];
      end
    end
  end

  assign bus.mem_valid     = r_valid;
  assign bus.mem_reg_write = r_reg_write;
  assign bus.mem_mem_read  = r_mem_read;
  assign bus.mem_mem_write = r_mem_write;
  assign bus.mem_result    = r_result;
  assign bus.mem_rs2_data  = r_rs2_data;
  assign bus.mem_rd        = r_rd;
  assign bus.mem_funct3    = r_funct3;
  assign bus.redirect      = r_redirect;
  assign bus.redirect_pc   = r_redirect_pc;
  assign bus.misalign      = r_misalign;
endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// tb_ex_mem_branch_stage: directed vectors with hand-computed expectations for ex_mem_branch_stage
module tb_ex_mem_branch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;

  ex_mem_branch_stage_if bus ();
  ex_mem_branch_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.stall = 0; bus.ex_valid = 0; bus.ex_alu_r = 0;
    bus.ex_cf = 0; bus.ex_zf = 0; bus.ex_vf = 0; bus.ex_sf = 0;
    bus.ex_branch = 0; bus.ex_jal = 0; bus.ex_jalr = 0; bus.ex_funct3 = 0;
    bus.ex_pc = 0; bus.ex_imm = 0; bus.ex_rs2_data = 0; bus.ex_rd = 0;
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_mem_write = 0;
  endtask

  // flags of a - b as the ALU produces them for branches
  task automatic set_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a - b;
    bus.ex_cf = (a >= b);
    bus.ex_zf = (r == 0);
    bus.ex_sf = r[31];
    bus.ex_vf = (a[31] != b[31]) && (r[31] != a[31]);
  endtask

  task automatic branch(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic exp);
    clear();
    bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_funct3 = f3;
    bus.ex_pc = 32'h200; bus.ex_imm = 32'h10;
    set_flags(a, b);
    tick();
    check({tag, "_redirect"}, {31'd0, bus.redirect}, {31'd0, exp});
    if (exp) check({tag, "_pc"}, bus.redirect_pc, 32'h210);
    clear();
    tick();
    tick();
  endtask

  initial begin
    clear();
    tick();
    tick();
    check("rst_valid", {31'd0, bus.mem_valid}, 0);
    check("rst_regw", {31'd0, bus.mem_reg_write}, 0);
    check("rst_result", bus.mem_result, 0);
    check("rst_redirect", {31'd0, bus.redirect}, 0);
    check("rst_rpc", bus.redirect_pc, 0);
    check("rst_misalign", {31'd0, bus.misalign}, 0);
    check("rst_rd", {27'd0, bus.mem_rd}, 0);
    rst = 0;

    bus.ex_valid = 1; bus.ex_alu_r = 32'h1234; bus.ex_reg_write = 1; bus.ex_rd = 5;
    tick();
    check("cap_result", bus.mem_result, 32'h1234);
    check("cap_rd", {27'd0, bus.mem_rd}, 5);
    check("cap_valid", {31'd0, bus.mem_valid}, 1);
    check("cap_regw", {31'd0, bus.mem_reg_write}, 1);
    check("cap_redirect", {31'd0, bus.redirect}, 0);

    clear();
    bus.ex_valid = 1; bus.ex_mem_write = 1; bus.ex_rs2_data = 32'hCAFE; bus.ex_funct3 = 3'b010;
    tick();
    check("st_memw", {31'd0, bus.mem_mem_write}, 1);
    check("st_data", bus.mem_rs2_data, 32'hCAFE);
    check("st_f3", {29'd0, bus.mem_funct3}, 2);

    clear();
    bus.ex_reg_write = 1;
    tick();
    check("inv_valid", {31'd0, bus.mem_valid}, 0);
    check("inv_regw", {31'd0, bus.mem_reg_write}, 0);

    clear();
    bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_funct3 = 3'b000; bus.ex_zf = 1;
    bus.ex_pc = 32'h100; bus.ex_imm = 32'h20;
    tick();
    check("beq_redirect", {31'd0, bus.redirect}, 1);
    check("beq_pc", bus.redirect_pc, 32'h120);
    check("beq_valid", {31'd0, bus.mem_valid}, 1);
    clear();
    bus.ex_valid = 1; bus.ex_jal = 1; bus.ex_reg_write = 1; bus.ex_pc = 32'h104; bus.ex_imm = 32'h80;
    tick();
    check("beq_pulse_end", {31'd0, bus.redirect}, 0);
    check("beq_squash_valid", {31'd0, bus.mem_valid}, 0);
    check("beq_squash_regw", {31'd0, bus.mem_reg_write}, 0);
    check("beq_pc_hold", bus.redirect_pc, 32'h120);
    clear();
    bus.ex_valid = 1; bus.ex_alu_r = 32'h99;
    tick();
    check("beq_next_valid", {31'd0, bus.mem_valid}, 1);
    check("beq_no_second", {31'd0, bus.redirect}, 0);
    clear();
    tick();

    branch("bgeu_t", 3'b111, 32'hFFFFFFFF, 32'h1, 1);
    branch("bltu_n", 3'b110, 32'hFFFFFFFF, 32'h1, 0);
    branch("blt_n", 3'b100, 32'h7FFFFFFF, 32'h80000000, 0);
    branch("bge_t", 3'b101, 32'h7FFFFFFF, 32'h80000000, 1);
    branch("bne_n", 3'b001, 32'h5, 32'h5, 0);
    branch("f3_010_n", 3'b010, 32'h5, 32'h5, 0);
    branch("bltu_t", 3'b110, 32'h1, 32'h2, 1);

    clear();
    bus.ex_valid = 1; bus.ex_jalr = 1; bus.ex_reg_write = 1; bus.ex_alu_r = 32'h203; bus.ex_pc = 32'h40;
    tick();
    check("jalr_redirect", {31'd0, bus.redirect}, 1);
    check("jalr_pc", bus.redirect_pc, 32'h202);
    check("jalr_misalign", {31'd0, bus.misalign}, 1);
    check("jalr_link", bus.mem_result, 32'h44);
    clear();
    tick();
    tick();

    bus.ex_valid = 1; bus.ex_jal = 1; bus.ex_pc = 32'hFFFFFFFC; bus.ex_imm = 32'h8;
    tick();
    check("jal_redirect", {31'd0, bus.redirect}, 1);
    check("jal_wrap_pc", bus.redirect_pc, 32'h4);
    check("jal_misalign", {31'd0, bus.misalign}, 0);
    check("jal_link_wrap", bus.mem_result, 32'h0);
    clear();
    tick();
    tick();

    bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_funct3 = 3'b000; bus.ex_zf = 1;
    bus.ex_pc = 32'h300; bus.ex_imm = 32'h40;
    tick();
    check("stl_redirect", {31'd0, bus.redirect}, 1);
    clear();
    bus.stall = 1; bus.ex_valid = 1; bus.ex_alu_r = 32'h55; bus.ex_rd = 7; bus.ex_reg_write = 1;
    tick();
    check("stl_pulse1", {31'd0, bus.redirect}, 0);
    check("stl_hold_valid", {31'd0, bus.mem_valid}, 1);
    tick();
    check("stl_pulse2", {31'd0, bus.redirect}, 0);
    tick();
    check("stl_pulse3", {31'd0, bus.redirect}, 0);
    check("stl_pc_hold", bus.redirect_pc, 32'h340);
    bus.stall = 0;
    tick();
    check("stl_squash", {31'd0, bus.mem_valid}, 0);
    bus.ex_alu_r = 32'h66;
    tick();
    check("stl_after_valid", {31'd0, bus.mem_valid}, 1);
    check("stl_after_result", bus.mem_result, 32'h66);
    clear();
    tick();

    bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_funct3 = 3'b000; bus.ex_zf = 1;
    bus.ex_pc = 32'h500; bus.ex_imm = 32'h8;
    tick();
    check("rr_redirect", {31'd0, bus.redirect}, 1);
    clear();
    rst = 1;
    bus.ex_valid = 1; bus.ex_alu_r = 32'h11;
    tick();
    check("rr_redirect_off", {31'd0, bus.redirect}, 0);
    check("rr_valid", {31'd0, bus.mem_valid}, 0);
    check("rr_rpc", bus.redirect_pc, 0);
    rst = 0;
    bus.ex_alu_r = 32'h77;
    tick();
    check("rr_squash_clear", {31'd0, bus.mem_valid}, 1);
    check("rr_result", bus.mem_result, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
